clk_quad_div_ctrl: RTL and testbench

Programmable quadrature clock divider controller. It derives a slow clock `clk_o` and its 90°-shifted copy `clk90_o` from the fast system clock. The divide ratio is loaded through a valid/ready configuration port and applied only at period boundaries, and start/stop is sequenced so that every emitted period is complete. It sits between the SoC/testbench control logic and peripheral clock consumers that need a divided clock plus a quarter-period-shifted sampling clock.

---
 rtl/clk_quad_div_pkg.sv | 13 +
 rtl/clk_quad_div_cfg_slot.sv | 54 +++++
 rtl/clk_quad_div_ctrl.sv | 106 ++++++++++
 tb/tb_clk_quad_div_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_quad_div_pkg.sv
// Shared types and constants for the quadrature clock divider controller.
package clk_quad_div_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } clk_div_state_e;

  localparam int unsigned MIN_QUARTER   = 1;
  localparam int unsigned RESET_QUARTER = MIN_QUARTER;

endpackage

// File: rtl/clk_quad_div_cfg_slot.sv
// Pending quarter-period slot: valid/ready acceptance, zero clamping and the
// strobe that hands the pending value to the active register at a wrap.
module clk_quad_div_cfg_slot
  import clk_quad_div_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_valid_i,
  input  logic [CNT_WIDTH-1:0] cfg_quarter_i,
  input  logic                 running_i,
  input  logic                 wrap_i,
  output logic                 cfg_ready_o,
  output logic                 accept_o,
  output logic [CNT_WIDTH-1:0] quarter_o,
  output logic                 apply_o,
  output logic [CNT_WIDTH-1:0] q_pend_o
);

  logic                 pend_vld_q, pend_vld_d;
  logic [CNT_WIDTH-1:0] q_pend_q, q_pend_d;

  // Handshake: a transfer happens on any edge where cfg_valid_i && cfg_ready_o.
  assign cfg_ready_o = !pend_vld_q;
  assign accept_o    = cfg_valid_i && !pend_vld_q;
  assign quarter_o   = (cfg_quarter_i == '0) ? CNT_WIDTH'(MIN_QUARTER) : cfg_quarter_i;
  assign apply_o     = wrap_i && pend_vld_q;
  assign q_pend_o    = q_pend_q;

  // accept needs an empty slot and apply needs a full one, so they never overlap.
  always_comb begin
    pend_vld_d = pend_vld_q;
    q_pend_d   = q_pend_q;
    if (apply_o) begin
      pend_vld_d = 1'b0;
    end
    if (accept_o && running_i) begin
      pend_vld_d = 1'b1;
      q_pend_d   = quarter_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_vld_q <= 1'b0;
      q_pend_q   <= CNT_WIDTH'(RESET_QUARTER);
    end else begin
      pend_vld_q <= pend_vld_d;
      q_pend_q   <= q_pend_d;
    end
  end

endmodule

// File: rtl/clk_quad_div_ctrl.sv
// Programmable quadrature clock divider: period 4Q, clk90_o lags clk_o by Q,
// ratio changes and stops only take effect at period boundaries.
module clk_quad_div_ctrl
  import clk_quad_div_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [CNT_WIDTH-1:0] cfg_quarter_i,
  output logic                 clk_o,
  output logic                 clk90_o,
  output logic                 period_o,
  output logic                 busy_o
);

  localparam int CW2 = CNT_WIDTH + 2;

  clk_div_state_e       state_q, state_d;
  logic [CW2-1:0]       cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] q_act_q, q_act_d;
  logic                 clk_q, clk90_q, period_q;

  logic                 running, wrap, accept, apply;
  logic [CNT_WIDTH-1:0] quarter_in, q_pend;
  logic [CW2-1:0]       end_cnt, q_ext, half_ext, three_ext;

  assign running = (state_q != IDLE);
  assign end_cnt = {q_act_q, 2'b00} - CW2'(1);
  assign wrap    = running && (cnt_q == end_cnt);

  clk_quad_div_cfg_slot #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_cfg_slot (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_quarter_i(cfg_quarter_i),
    .running_i    (running),
    .wrap_i       (wrap),
    .cfg_ready_o  (cfg_ready_o),
    .accept_o     (accept),
    .quarter_o    (quarter_in),
    .apply_o      (apply),
    .q_pend_o     (q_pend)
  );

  // Raising en_i again while stopping simply resumes; the counter never restarts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_act_d = q_act_q;
    case (state_q)
      IDLE: begin
        if (accept) q_act_d = quarter_in;
        if (en_i) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN, STOPPING: begin
        if (wrap) begin
          cnt_d   = '0;
          state_d = en_i ? RUN : IDLE;
          if (apply) q_act_d = q_pend;
        end else begin
          cnt_d   = cnt_q + CW2'(1);
          state_d = en_i ? RUN : STOPPING;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next-state so they line up with the count they describe.
  assign q_ext     = {2'b00, q_act_d};
  assign half_ext  = {1'b0, q_act_d, 1'b0};
  assign three_ext = half_ext + q_ext;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      q_act_q  <= CNT_WIDTH'(RESET_QUARTER);
      clk_q    <= 1'b0;
      clk90_q  <= 1'b0;
      period_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      q_act_q  <= q_act_d;
      clk_q    <= (state_d != IDLE) && (cnt_d < half_ext);
      clk90_q  <= (state_d != IDLE) && (cnt_d >= q_ext) && (cnt_d < three_ext);
      period_q <= (state_d != IDLE) && (cnt_d == '0);
    end
  end

  assign clk_o    = clk_q;
  assign clk90_o  = clk90_q;
  assign period_o = period_q;
  assign busy_o   = running;

endmodule

// File: tb/tb_clk_quad_div_ctrl.sv
// Self-checking bench for clk_quad_div_ctrl: vector table, directed corner
// sequences and a randomized run against a period/position reference model.
module tb_clk_quad_div_ctrl;

  localparam int CW = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          en_i;
  logic          cfg_valid_i;
  logic          cfg_ready_o;
  logic [CW-1:0] cfg_quarter_i;
  logic          clk_o, clk90_o, period_o, busy_o;

  clk_quad_div_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_ready_o  (cfg_ready_o),
    .cfg_quarter_i(cfg_quarter_i),
    .clk_o        (clk_o),
    .clk90_o      (clk90_o),
    .period_o     (period_o),
    .busy_o       (busy_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // reference model: running flag, position within period, quarter, pending (-1 = none)
  bit m_act;
  int m_pos;
  int m_q;
  int m_pend;

  task automatic model_reset();
    m_act  = 1'b0;
    m_pos  = 0;
    m_q    = 1;
    m_pend = -1;
  endtask

  task automatic model_step(input bit en, input bit v, input int qv);
    bit acc;
    int val;
    acc = v && (m_pend < 0);
    val = (qv == 0) ? 1 : qv;
    if (!m_act) begin
      if (acc) m_q = val;
      if (en) begin
        m_act = 1'b1;
        m_pos = 0;
      end
    end else begin
      if (m_pos == 4 * m_q - 1) begin
        if (m_pend >= 0) begin
          m_q    = m_pend;
          m_pend = -1;
        end
        m_pos = 0;
        if (!en) m_act = 1'b0;
      end else begin
        m_pos++;
      end
      if (acc) m_pend = val;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    check("clk_o",       int'(clk_o),       int'(m_act && (m_pos < 2 * m_q)));
    check("clk90_o",     int'(clk90_o),     int'(m_act && (m_pos >= m_q) && (m_pos < 3 * m_q)));
    check("period_o",    int'(period_o),    int'(m_act && (m_pos == 0)));
    check("busy_o",      int'(busy_o),      int'(m_act));
    check("cfg_ready_o", int'(cfg_ready_o), int'(m_pend < 0));
  endtask

  // driver: inputs change at negedge, DUT samples at posedge, checked at next negedge
  task automatic step(input bit en, input bit v, input logic [CW-1:0] qv);
    en_i          = en;
    cfg_valid_i   = v;
    cfg_quarter_i = qv;
    @(posedge clk_i);
    model_step(en, v, int'(qv));
    @(negedge clk_i);
    check_all();
    cfg_valid_i = 1'b0;
  endtask

  task automatic go_idle();
    int k;
    k = 0;
    while (m_act && k < 200) begin
      step(1'b0, 1'b0, '0);
      k++;
    end
    check("go_idle_busy", int'(busy_o), 0);
  endtask

  task automatic count_to_period(output int n);
    n = 0;
    do begin
      step(1'b1, 1'b0, '0);
      n++;
    end while (!period_o && n < 100);
  endtask

  task automatic run_to_pos(input int p);
    int k;
    k = 0;
    while (m_pos != p && k < 100) begin
      step(1'b1, 1'b0, '0);
      k++;
    end
    check("run_to_pos", m_pos, p);
  endtask

  typedef struct {
    bit            en;
    bit            v;
    logic [CW-1:0] q;
    bit            e_clk;
    bit            e_c90;
    bit            e_per;
    bit            e_busy;
    bit            e_rdy;
  } vec_t;

  vec_t        tab[25];
  logic [11:0] clk_pat;
  logic [11:0] c90_pat;
  logic [11:0] per_pat;

  initial begin
    int n;
    bit busy_ok;
    bit en_r, v_r;
    logic [CW-1:0] q_r;

    // Q=3 expected waveform, index c=0 is the MSB
    clk_pat = 12'b111111000000;
    c90_pat = 12'b000111111000;
    per_pat = 12'b100000000000;
    tab[0] = '{1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 24; i++) begin
      tab[i+1] = '{1'b1, 1'b0, 8'd0, clk_pat[11 - (i % 12)], c90_pat[11 - (i % 12)],
                   per_pat[11 - (i % 12)], 1'b1, 1'b1};
    end

    rst_i         = 1'b1;
    en_i          = 1'b0;
    cfg_valid_i   = 1'b0;
    cfg_quarter_i = '0;
    model_reset();
    #12;
    check("rst_clk_o",   int'(clk_o),       0);
    check("rst_clk90_o", int'(clk90_o),     0);
    check("rst_period",  int'(period_o),    0);
    check("rst_busy",    int'(busy_o),      0);
    check("rst_ready",   int'(cfg_ready_o), 1);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Q=3 loaded in IDLE, then two 12-cycle periods
    for (int i = 0; i < 25; i++) begin
      step(tab[i].en, tab[i].v, tab[i].q);
      check("tab_clk",   int'(clk_o),       int'(tab[i].e_clk));
      check("tab_clk90", int'(clk90_o),     int'(tab[i].e_c90));
      check("tab_per",   int'(period_o),    int'(tab[i].e_per));
      check("tab_busy",  int'(busy_o),      int'(tab[i].e_busy));
      check("tab_ready", int'(cfg_ready_o), int'(tab[i].e_rdy));
    end
    go_idle();

    // Q=2 running, Q=5 offered at cnt=3
    step(1'b0, 1'b1, 8'd2);
    step(1'b1, 1'b0, '0);
    run_to_pos(3);
    step(1'b1, 1'b1, 8'd5);
    check("s2_ready_low", int'(cfg_ready_o), 0);
    count_to_period(n);
    check("s2_tail_len", n, 4);
    check("s2_ready_high", int'(cfg_ready_o), 1);
    count_to_period(n);
    check("s2_period20", n, 20);
    go_idle();

    // Q=2, en dropped at cnt=1: period finishes, then idle
    step(1'b0, 1'b1, 8'd2);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    n = 0;
    do begin
      step(1'b0, 1'b0, '0);
      n++;
    end while (busy_o && n < 50);
    check("s3_stop_len", n, 7);
    check("s3_clk_low", int'(clk_o), 0);

    // drop at cnt=2, re-raise at cnt=5: seamless
    step(1'b1, 1'b0, '0);
    run_to_pos(2);
    busy_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0);
      busy_ok &= busy_o;
    end
    step(1'b1, 1'b0, '0);
    busy_ok &= busy_o;
    check("s4_busy_held", int'(busy_ok), 1);
    count_to_period(n);
    check("s4_wrap_dist", n, 2);
    go_idle();

    // Q=0 behaves as Q=1; handshake on the wrap edge waits one period
    step(1'b0, 1'b1, 8'd0);
    step(1'b1, 1'b0, '0);
    count_to_period(n);
    check("s5_q0_period", n, 4);
    run_to_pos(3);
    step(1'b1, 1'b1, 8'd2);
    check("s5_wrap_period", int'(period_o), 1);
    check("s5_wrap_pending", int'(cfg_ready_o), 0);
    count_to_period(n);
    check("s5_old_period", n, 4);
    count_to_period(n);
    check("s5_new_period", n, 8);

    // asynchronous reset mid-period with a pending configuration
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 8'd3);
    check("s6_pre_busy", int'(busy_o), 1);
    check("s6_pre_clk90", int'(clk90_o), 1);
    #2;
    en_i  = 1'b0;
    rst_i = 1'b1;
    #1;
    check("s6_async_clk90", int'(clk90_o),     0);
    check("s6_async_clk",   int'(clk_o),       0);
    check("s6_async_busy",  int'(busy_o),      0);
    check("s6_async_ready", int'(cfg_ready_o), 1);
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    check_all();
    step(1'b1, 1'b0, '0);
    count_to_period(n);
    check("s6_q_reset", n, 4);

    // randomized run
    for (int i = 0; i < 600; i++) begin
      en_r = ($urandom_range(0, 9) < 7);
      v_r  = ($urandom_range(0, 3) == 0);
      q_r  = CW'($urandom_range(0, 4));
      step(en_r, v_r, q_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
